// File: rtl/sram_arb_bridge_if.sv
// SRAM-style request channel: request fields flow master->slave, accept/completion flow back.
// The bridge is a slave on each CPU-side channel and a master on the memory side.
interface sram_arb_bridge_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned SW = DATA_W / 8;

    logic              req;
    logic              wr;
    logic [SW-1:0]     wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_arb_bridge.sv
// Arbitrates an instruction and a data SRAM-style channel onto one memory channel,
// one transaction in flight, with an optional DATA-phase timeout that forces completion.
module sram_arb_bridge #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ARB_MODE = 0,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              resetn,
    sram_arb_bridge_if.slave  i_bus,
    sram_arb_bridge_if.slave  d_bus,
    sram_arb_bridge_if.master m_bus,
    output logic              err
);
    localparam int unsigned SW = DATA_W / 8;
    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e        state_q, state_d;
    // 1 = data channel; the current grant also serves as the round-robin history.
    logic          gnt_q, gnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntLast);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            gnt_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        cnt_d         = cnt_q;
        m_bus.req     = 1'b0;
        m_bus.wr      = 1'b0;
        m_bus.wstrb   = '0;
        m_bus.addr    = '0;
        m_bus.wdata   = '0;
        i_bus.addr_ok = 1'b0;
        i_bus.data_ok = 1'b0;
        i_bus.rdata   = '0;
        d_bus.addr_ok = 1'b0;
        d_bus.data_ok = 1'b0;
        d_bus.rdata   = '0;
        err           = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_bus.req || d_bus.req) begin
                    if (i_bus.req && d_bus.req) begin
                        gnt_d = (ARB_MODE == 0) ? 1'b1 : ~gnt_q;
                    end else begin
                        gnt_d = d_bus.req;
                    end
                    state_d = StAddr;
                end
            end

            StAddr: begin
                m_bus.req   = 1'b1;
                m_bus.wr    = gnt_q ? d_bus.wr    : i_bus.wr;
                m_bus.wstrb = gnt_q ? d_bus.wstrb : i_bus.wstrb;
                m_bus.addr  = gnt_q ? d_bus.addr  : i_bus.addr;
                m_bus.wdata = gnt_q ? d_bus.wdata : i_bus.wdata;
                if (m_bus.addr_ok) begin
                    if (gnt_q) begin
                        d_bus.addr_ok = 1'b1;
                    end else begin
                        i_bus.addr_ok = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = StData;
                end
            end

            StData: begin
                cnt_d = cnt_q + 1'b1;
                // A real response in the timeout cycle wins and completes without error.
                if (m_bus.data_ok) begin
                    if (gnt_q) begin
                        d_bus.data_ok = 1'b1;
                        d_bus.rdata   = m_bus.rdata;
                    end else begin
                        i_bus.data_ok = 1'b1;
                        i_bus.rdata   = m_bus.rdata;
                    end
                    state_d = StIdle;
                end else if (timeout_hit) begin
                    if (gnt_q) begin
                        d_bus.data_ok = 1'b1;
                    end else begin
                        i_bus.data_ok = 1'b1;
                    end
                    err     = 1'b1;
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    logic unused_sw;
    assign unused_sw = (SW == 0);
endmodule

// File: tb/tb_sram_arb_bridge.sv
// Directed bench for sram_arb_bridge: a fixed-priority and a round-robin instance share stimulus;
// expected transactions are queued per instance and checked as each one is accepted and completed.
module tb_sram_arb_bridge;
    typedef struct packed {
        logic        chan;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic        i_req, i_wr, d_req, d_wr;
    logic [3:0]  i_wstrb, d_wstrb;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;
    logic        err0, err1;

    int   checks;
    int   passes;
    exp_t sb0[$];
    exp_t sb1[$];

    sram_arb_bridge_if #(.ADDR_W(32), .DATA_W(32)) i0 ();
    sram_arb_bridge_if #(.ADDR_W(32), .DATA_W(32)) d0 ();
    sram_arb_bridge_if #(.ADDR_W(32), .DATA_W(32)) m0 ();
    sram_arb_bridge_if #(.ADDR_W(32), .DATA_W(32)) i1 ();
    sram_arb_bridge_if #(.ADDR_W(32), .DATA_W(32)) d1 ();
    sram_arb_bridge_if #(.ADDR_W(32), .DATA_W(32)) m1 ();

    assign i0.req = i_req;  assign i0.wr = i_wr;  assign i0.wstrb = i_wstrb;
    assign i0.addr = i_addr;  assign i0.wdata = i_wdata;
    assign d0.req = d_req;  assign d0.wr = d_wr;  assign d0.wstrb = d_wstrb;
    assign d0.addr = d_addr;  assign d0.wdata = d_wdata;
    assign i1.req = i_req;  assign i1.wr = i_wr;  assign i1.wstrb = i_wstrb;
    assign i1.addr = i_addr;  assign i1.wdata = i_wdata;
    assign d1.req = d_req;  assign d1.wr = d_wr;  assign d1.wstrb = d_wstrb;
    assign d1.addr = d_addr;  assign d1.wdata = d_wdata;
    assign m0.addr_ok = m_addr_ok;  assign m0.data_ok = m_data_ok;  assign m0.rdata = m_rdata;
    assign m1.addr_ok = m_addr_ok;  assign m1.data_ok = m_data_ok;  assign m1.rdata = m_rdata;

    sram_arb_bridge #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(0), .TIMEOUT(4)) u_dut0 (
        .clk    (clk),
        .resetn (resetn),
        .i_bus  (i0),
        .d_bus  (d0),
        .m_bus  (m0),
        .err    (err0)
    );

    sram_arb_bridge #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(1), .TIMEOUT(4)) u_dut1 (
        .clk    (clk),
        .resetn (resetn),
        .i_bus  (i1),
        .d_bus  (d1),
        .m_bus  (m1),
        .err    (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        assert (act === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    endtask

    function automatic exp_t mk(input logic chan, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.chan  = chan;
        e.wr    = chan ? d_wr    : i_wr;
        e.wstrb = chan ? d_wstrb : i_wstrb;
        e.addr  = chan ? d_addr  : i_addr;
        e.wdata = chan ? d_wdata : i_wdata;
        e.rdata = rdata;
        e.err   = err;
        return e;
    endfunction

    task automatic check_one(input int k, input logic mreq, input logic mwr,
                             input logic [3:0] mwstrb, input logic [31:0] maddr,
                             input logic [31:0] mwdata, input logic iaok, input logic daok,
                             input logic idok, input logic ddok, input logic [31:0] ird,
                             input logic [31:0] drd, input logic derr);
        exp_t  e;
        bit    have;
        string tag;
        tag  = $sformatf("dut%0d", k);
        e    = '0;
        have = (k == 0) ? (sb0.size() != 0) : (sb1.size() != 0);
        if (have) e = (k == 0) ? sb0[0] : sb1[0];
        if (mreq) begin
            chk({tag, "_req_expected"}, 128'(have), 128'(1));
            if (have) begin
                chk({tag, "_mem_fields"}, {mwr, mwstrb, maddr, mwdata},
                    {e.wr, e.wstrb, e.addr, e.wdata});
                chk({tag, "_addr_ok"}, {iaok, daok},
                    m_addr_ok ? (e.chan ? 2'b01 : 2'b10) : 2'b00);
            end
        end else begin
            chk({tag, "_idle_outputs"}, {mwr, mwstrb, maddr, mwdata, iaok, daok}, '0);
        end
        if (idok || ddok || derr) begin
            chk({tag, "_done_expected"}, 128'(have), 128'(1));
            if (have) begin
                if (k == 0) void'(sb0.pop_front());
                else void'(sb1.pop_front());
                chk({tag, "_completion"}, {idok, ddok, ird, drd, derr},
                    {~e.chan, e.chan, e.chan ? 32'h0 : e.rdata, e.chan ? e.rdata : 32'h0, e.err});
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_one(0, m0.req, m0.wr, m0.wstrb, m0.addr, m0.wdata, i0.addr_ok, d0.addr_ok,
                  i0.data_ok, d0.data_ok, i0.rdata, d0.rdata, err0);
        check_one(1, m1.req, m1.wr, m1.wstrb, m1.addr, m1.wdata, i1.addr_ok, d1.addr_ok,
                  i1.data_ok, d1.data_ok, i1.rdata, d1.rdata, err1);
        @(posedge clk);
        #1;
    endtask

    // IDLE, ADDR, then n DATA cycles; the memory answers on the last one when resp is set.
    task automatic run_txn(input int n, input bit resp, input logic [31:0] rdata);
        m_rdata = rdata;
        tick();
        tick();
        for (int c = 1; c <= n; c++) begin
            m_data_ok = resp && (c == n);
            tick();
        end
        m_data_ok = 1'b0;
    endtask

    initial begin
        checks    = 0;
        passes    = 0;
        resetn    = 1'b0;
        i_req     = 1'b0;  i_wr = 1'b0;  i_wstrb = 4'h0;  i_addr = '0;  i_wdata = '0;
        d_req     = 1'b0;  d_wr = 1'b0;  d_wstrb = 4'h0;  d_addr = '0;  d_wdata = '0;
        m_addr_ok = 1'b1;
        m_data_ok = 1'b0;
        m_rdata   = '0;
        tick();
        tick();
        resetn = 1'b1;
        tick();

        // Single data read, completion in the second DATA cycle.
        d_req  = 1'b1;
        d_addr = 32'h1FC0_0010;
        sb0.push_back(mk(1'b1, 32'hDEAD_BEEF, 1'b0));
        sb1.push_back(mk(1'b1, 32'hDEAD_BEEF, 1'b0));
        run_txn(2, 1'b1, 32'hDEAD_BEEF);
        d_req = 1'b0;
        tick();

        // Reset in DATA abandons the transaction; a stray m_data_ok must not complete it.
        d_req  = 1'b1;
        d_addr = 32'h0000_0040;
        sb0.push_back(mk(1'b1, 32'h0, 1'b0));
        sb1.push_back(mk(1'b1, 32'h0, 1'b0));
        m_rdata = 32'h5555_AAAA;
        tick();
        tick();
        d_req = 1'b0;
        tick();
        resetn    = 1'b0;
        m_data_ok = 1'b1;
        sb0.delete();
        sb1.delete();
        tick();
        tick();
        resetn = 1'b1;
        tick();
        m_data_ok = 1'b0;
        tick();

        // Both channels requesting continuously: fixed priority vs round robin.
        i_req   = 1'b1;  i_wr = 1'b1;  i_wstrb = 4'b0011;
        i_addr  = 32'hA000_0000;  i_wdata = 32'hCAFE_F00D;
        d_req   = 1'b1;  d_wr = 1'b0;  d_wstrb = 4'b0000;
        d_addr  = 32'hB000_0004;  d_wdata = 32'h0;
        for (int t = 0; t < 4; t++) begin
            sb0.push_back(mk(1'b1, 32'h1000_0000 + t, 1'b0));
            sb1.push_back(mk((t % 2) == 0, 32'h1000_0000 + t, 1'b0));
            run_txn(1, 1'b1, 32'h1000_0000 + t);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        tick();

        // Instruction channel alone, byte-strobed write.
        i_req   = 1'b1;  i_wstrb = 4'b1100;  i_addr = 32'h0000_1000;  i_wdata = 32'h1234_5678;
        sb0.push_back(mk(1'b0, 32'h0BAD_F00D, 1'b0));
        sb1.push_back(mk(1'b0, 32'h0BAD_F00D, 1'b0));
        run_txn(1, 1'b1, 32'h0BAD_F00D);
        i_req = 1'b0;
        tick();

        // Timeout: no response for four DATA cycles forces completion with err and zero data.
        d_req  = 1'b1;
        d_addr = 32'h2000_0000;
        sb0.push_back(mk(1'b1, 32'h0, 1'b1));
        sb1.push_back(mk(1'b1, 32'h0, 1'b1));
        run_txn(4, 1'b0, 32'h7777_7777);
        d_req = 1'b0;
        tick();

        // Response in the timeout cycle is a normal completion.
        d_req  = 1'b1;
        d_addr = 32'h2000_0008;
        sb0.push_back(mk(1'b1, 32'h8888_1111, 1'b0));
        sb1.push_back(mk(1'b1, 32'h8888_1111, 1'b0));
        run_txn(4, 1'b1, 32'h8888_1111);
        d_req = 1'b0;
        tick();
        tick();

        chk("dut0_all_completed", 128'(sb0.size()), 128'(0));
        chk("dut1_all_completed", 128'(sb1.size()), 128'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/sram_arb_bridge.md
SRAM_ARB_BRIDGE -- requirements
Module: sram_arb_bridge

Interface
REQ-001 Parameter ADDR_W, default 32: address width of all channels.
REQ-002 Parameter DATA_W, default 32: data width; must be a multiple of 8; strobe width SW = DATA_W/8.
REQ-003 Parameter ARB_MODE, default 0: 0 = fixed data-channel priority; 1 = round-robin.
REQ-004 Parameter TIMEOUT, default 255: maximum DATA-state cycles before forced completion; 0 disables the timeout.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 i_req, i_wr  in  1 each  instruction-channel request and write flag.
REQ-008 i_wstrb  in  SW  instruction-channel byte strobes.
REQ-009 i_addr  in  ADDR_W  instruction-channel address.
REQ-010 i_wdata  in  DATA_W  instruction-channel write data.
REQ-011 i_addr_ok, i_data_ok  out  1 each  instruction-channel address-accept and completion pulses.
REQ-012 i_rdata  out  DATA_W  instruction-channel read data.
REQ-013 d_req, d_wr, d_wstrb, d_addr, d_wdata, d_addr_ok, d_data_ok, d_rdata: data channel; same widths and directions as the i_* ports.
REQ-014 m_req, m_wr  out  1 each  shared memory-side request and write flag.
REQ-015 m_wstrb  out  SW  memory-side byte strobes.
REQ-016 m_addr  out  ADDR_W  memory-side address.
REQ-017 m_wdata  out  DATA_W  memory-side write data.
REQ-018 m_addr_ok, m_data_ok  in  1 each  memory-side address accept and completion.
REQ-019 m_rdata  in  DATA_W  memory-side read data.
REQ-020 err  out  1  one-cycle pulse on timeout completion.

Function
REQ-021 FSM states: IDLE, ADDR, DATA; one transaction in flight at most.
REQ-022 IDLE: if i_req or d_req, latch grant (gnt) and go to ADDR next cycle; else stay.
REQ-023 ARB_MODE=0: d_req wins when both channels request.
REQ-024 ARB_MODE=1: when both request, grant the channel not granted last; last-grant register updates on each grant.
REQ-025 ARB_MODE=1: a single requester is granted regardless of the last-grant register.
REQ-026 ADDR: m_req=1; m_wr, m_wstrb, m_addr, m_wdata are driven combinationally from the granted channel; channels hold their fields until addr_ok.
REQ-027 ADDR: m_addr_ok=1 pulses the granted channel's addr_ok in the same cycle; next state is DATA.
REQ-028 In all non-ADDR states: m_req=0; m_wr, m_wstrb, m_addr, m_wdata are 0.
REQ-029 DATA: m_data_ok=1 pulses the granted channel's data_ok and passes m_rdata to its rdata in the same cycle; next state is IDLE.
REQ-030 The non-granted channel's addr_ok, data_ok and rdata are 0 at all times; addr_ok and data_ok never pulse outside ADDR and DATA respectively.
REQ-031 Timeout counter: cleared on entry to DATA, increments each DATA cycle.
REQ-032 Timeout completion: counter reaching TIMEOUT-1 with m_data_ok=0 pulses the granted channel's data_ok with rdata=0, pulses err, and goes to IDLE.
REQ-033 If m_data_ok and the timeout are reached in the same cycle, it is a normal completion with no err.
REQ-034 m_data_ok in IDLE or ADDR and m_addr_ok outside ADDR are ignored.
REQ-035 Requests arriving during ADDR or DATA wait; they are arbitrated at the next IDLE.
REQ-036 Minimum per-transaction latency: req at cycle 0 -> m_req at cycle 1; minimum back-to-back spacing is one IDLE cycle.

Reset
REQ-037 resetn=0 immediately forces: state IDLE, gnt=inst, last-grant=inst, timeout counter 0, all outputs 0.
REQ-038 Reset mid-transaction abandons the transaction silently; no addr_ok, data_ok or err pulse follows.

Verification
REQ-039 d_req only, addr 0x1FC0_0010, read; m_addr_ok at cycle 1; m_data_ok at cycle 3 with m_rdata 0xDEADBEEF -> d_addr_ok at cycle 1; d_data_ok and d_rdata=0xDEADBEEF at cycle 3; i_* outputs stay 0.
REQ-040 ARB_MODE=0, i_req and d_req held for 3 transactions -> all 3 grants go to data.
REQ-041 ARB_MODE=1, both requesting continuously -> grants alternate d, i, d, i.
REQ-042 TIMEOUT=4, m_data_ok never asserted -> on the 4th DATA cycle: data_ok=1, rdata=0, err=1; state returns to IDLE.
REQ-043 TIMEOUT=4, m_data_ok on the 4th DATA cycle -> normal completion, err=0.
REQ-044 resetn pulled low in DATA, released 2 cycles later with no requests -> outputs stay 0, no stray data_ok.
